// File: rtl/binary_gray_conv_if.sv
// Bus interface for binary_gray_conv: qualified input word plus registered result.
// The out_par signal exists only when BINARY_GRAY_PARITY_EN is defined.
interface binary_gray_conv_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] num;
    logic             sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_sel;
`ifdef BINARY_GRAY_PARITY_EN
    logic             out_par;

    modport master (
        output in_valid, num, sel,
        input  out, out_valid, out_sel, out_par
    );

    modport slave (
        input  in_valid, num, sel,
        output out, out_valid, out_sel, out_par
    );
`else
    modport master (
        output in_valid, num, sel,
        input  out, out_valid, out_sel
    );

    modport slave (
        input  in_valid, num, sel,
        output out, out_valid, out_sel
    );
`endif
endinterface

// File: rtl/binary_gray_conv.sv
// Registered dual-direction binary/Gray converter, 1-cycle latency, full throughput.
// Optional registered parity output out_par enabled by BINARY_GRAY_PARITY_EN.
module binary_gray_conv #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    binary_gray_conv_if.slave bus
);

    logic [WIDTH-1:0] gray_word;
    logic [WIDTH-1:0] bin_word;
    logic [WIDTH-1:0] result;
    logic             acc;

    // Both directions are pure XOR networks; Gray->binary is a running XOR from the MSB down.
    always_comb begin
        gray_word = bus.num ^ (bus.num >> 1);
        bin_word  = '0;
        acc       = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc         = acc ^ bus.num[i];
            bin_word[i] = acc;
        end
        result = bus.sel ? bin_word : gray_word;
    end

    // Result and its mode are only captured on valid cycles, so X on an idle num never reaches out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sel   <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out     <= result;
                bus.out_sel <= bus.sel;
            end
        end
    end

`ifdef BINARY_GRAY_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_par <= 1'b0;
        end else if (bus.in_valid) begin
            bus.out_par <= ^result;
        end
    end
`endif

endmodule

// File: tb/tb_binary_gray_conv.sv
// Self-checking bench for binary_gray_conv at WIDTH=4 and WIDTH=8.
// Arithmetic reference model plus directed vectors with hand-computed results.
module tb_binary_gray_conv;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    binary_gray_conv_if #(.WIDTH(4)) bus4 ();
    binary_gray_conv_if #(.WIDTH(8)) bus8 ();

    binary_gray_conv #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    binary_gray_conv #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    function automatic logic [31:0] toGray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray->binary as the XOR of every right shift of the Gray word.
    function automatic logic [31:0] fromGray(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int s = 0; s < 32; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int w, input logic v, input logic [31:0] n,
                                 input logic s);
        @(negedge clk);
        if (w == 4) begin
            bus4.in_valid = v;
            bus4.num      = n[3:0];
            bus4.sel      = s;
        end else begin
            bus8.in_valid = v;
            bus8.num      = n[7:0];
            bus8.sel      = s;
        end
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp4_out   = '0;
    logic       exp4_valid = 1'b0;
    logic       exp4_sel   = 1'b0;
    logic [7:0] exp8_out   = '0;
    logic       exp8_valid = 1'b0;
    logic       exp8_sel   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp4_out   <= '0;
            exp4_valid <= 1'b0;
            exp4_sel   <= 1'b0;
            exp8_out   <= '0;
            exp8_valid <= 1'b0;
            exp8_sel   <= 1'b0;
        end else begin
            exp4_valid <= bus4.in_valid;
            if (bus4.in_valid) begin
                exp4_out <= 4'(bus4.sel ? fromGray(32'(bus4.num)) : toGray(32'(bus4.num)));
                exp4_sel <= bus4.sel;
            end
            exp8_valid <= bus8.in_valid;
            if (bus8.in_valid) begin
                exp8_out <= 8'(bus8.sel ? fromGray(32'(bus8.num)) : toGray(32'(bus8.num)));
                exp8_sel <= bus8.sel;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("model_valid4", 32'(bus4.out_valid), 32'(exp4_valid));
        checkOutput("model_out4",   32'(bus4.out),       32'(exp4_out));
        checkOutput("model_sel4",   32'(bus4.out_sel),   32'(exp4_sel));
        checkOutput("model_valid8", 32'(bus8.out_valid), 32'(exp8_valid));
        checkOutput("model_out8",   32'(bus8.out),       32'(exp8_out));
        checkOutput("model_sel8",   32'(bus8.out_sel),   32'(exp8_sel));
`ifdef BINARY_GRAY_PARITY_EN
        checkOutput("model_par4",   32'(bus4.out_par),   32'(^exp4_out));
        checkOutput("model_par8",   32'(bus8.out_par),   32'(^exp8_out));
`endif
    end

    initial begin
        logic [3:0] g4;
        logic [3:0] prev_g4;
        logic [7:0] g8;
        logic [7:0] prev_g8;

        bus4.in_valid = 1'b0;
        bus4.num      = '0;
        bus4.sel      = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.num      = '0;
        bus8.sel      = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset held with valid input present
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4, 1'b1, 32'b1010, 1'b0);
            checkOutput("rst_out",   32'(bus4.out),       32'b0);
            checkOutput("rst_valid", 32'(bus4.out_valid), 32'b0);
            checkOutput("rst_sel",   32'(bus4.out_sel),   32'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_valid", 32'(bus4.out_valid), 32'b1);
        checkOutput("release_out",   32'(bus4.out),       32'b1111);

        applyStimulus(4, 1'b1, 32'b0110, 1'b0);
        checkOutput("b2g_0110", 32'(bus4.out), 32'b0101);
        checkOutput("b2g_valid", 32'(bus4.out_valid), 32'b1);
        applyStimulus(4, 1'b1, 32'b0101, 1'b0);
        checkOutput("b2g_0101", 32'(bus4.out), 32'b0111);

        applyStimulus(4, 1'b1, 32'b0101, 1'b1);
        checkOutput("g2b_0101", 32'(bus4.out), 32'b0110);
        checkOutput("g2b_sel",  32'(bus4.out_sel), 32'b1);
        applyStimulus(4, 1'b1, 32'b0110, 1'b1);
        checkOutput("g2b_0110", 32'(bus4.out), 32'b0100);

        applyStimulus(4, 1'b1, 32'b1111, 1'b0);
        checkOutput("b2g_1111", 32'(bus4.out), 32'b1000);
        checkOutput("b2g_1111_sel", 32'(bus4.out_sel), 32'b0);
        applyStimulus(4, 1'b1, 32'b1111, 1'b1);
        checkOutput("g2b_1111", 32'(bus4.out), 32'b1010);

        // Idle cycle with X on num must hold the previous result
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bus4.num      = 'x;
        bus4.sel      = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold_valid", 32'(bus4.out_valid), 32'b0);
        checkOutput("hold_out",   32'(bus4.out),       32'b1010);
        checkOutput("hold_sel",   32'(bus4.out_sel),   32'b1);

        applyStimulus(4, 1'b1, 32'b0, 1'b0);
        checkOutput("zero_b2g", 32'(bus4.out), 32'b0);
        applyStimulus(4, 1'b1, 32'b0, 1'b1);
        checkOutput("zero_g2b", 32'(bus4.out), 32'b0);

        // Exhaustive WIDTH=4 round trip, single-bit steps and parity vs binary LSB
        prev_g4 = '0;
        for (int v = 0; v < 16; v++) begin
            applyStimulus(4, 1'b1, 32'(v), 1'b0);
            g4 = bus4.out;
`ifdef BINARY_GRAY_PARITY_EN
            checkOutput("par_lsb4", 32'(bus4.out_par), 32'(v & 1));
`endif
            if (v > 0) checkOutput("onebit4", 32'($countones(g4 ^ prev_g4)), 32'd1);
            prev_g4 = g4;
            applyStimulus(4, 1'b1, 32'(g4), 1'b1);
            checkOutput("roundtrip4", 32'(bus4.out), 32'(v));
        end

        // Asynchronous reset between edges
        applyStimulus(4, 1'b1, 32'b0101, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_out",   32'(bus4.out),       32'b0);
        checkOutput("async_valid", 32'(bus4.out_valid), 32'b0);
`ifdef BINARY_GRAY_PARITY_EN
        checkOutput("async_par",   32'(bus4.out_par),   32'b0);
`endif
        @(negedge clk);
        bus4.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_idle", 32'(bus4.out_valid), 32'b0);
        applyStimulus(4, 1'b1, 32'b0011, 1'b0);
        checkOutput("post_rst_valid", 32'(bus4.out_valid), 32'b1);
        checkOutput("post_rst_out",   32'(bus4.out),       32'b0010);
        @(negedge clk);
        bus4.in_valid = 1'b0;

        // Exhaustive WIDTH=8 round trip
        applyStimulus(8, 1'b1, 32'hFF, 1'b0);
        checkOutput("b2g8_ff", 32'(bus8.out), 32'h80);
        applyStimulus(8, 1'b1, 32'hFF, 1'b1);
        checkOutput("g2b8_ff", 32'(bus8.out), 32'hAA);
        prev_g8 = '0;
        for (int v = 0; v < 256; v++) begin
            applyStimulus(8, 1'b1, 32'(v), 1'b0);
            g8 = bus8.out;
            if (v > 0) checkOutput("onebit8", 32'($countones(g8 ^ prev_g8)), 32'd1);
            prev_g8 = g8;
            applyStimulus(8, 1'b1, 32'(g8), 1'b1);
            checkOutput("roundtrip8", 32'(bus8.out), 32'(v));
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
